// File: rtl/rho_step_core.sv
// ---------------------------------------------------------------------------
// rho_step_core
//
// Keccak-f rho step: every lane [x][y] of the state is rotated left (toward
// higher z) by a fixed offset OFF[x][y] mod LANE_SIZE. The offsets are
// resolved at elaboration, so each rotation is plain wiring. The result is
// registered, which gives one cycle of latency and a throughput of one state
// per cycle. There is no backpressure.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset; clears the output register
//   valid_in        state_array_in carries a state to transform this cycle
//   state_array_in  input state, indexed [x][y][z]
//   valid_out       state_array_out holds a result loaded on the last edge
//   state_array_out registered rho(state_array_in); holds its value when
//                   valid_in is low
// ---------------------------------------------------------------------------
module rho_step_core #(
    parameter int unsigned ROW_SIZE  = 5,
    parameter int unsigned COL_SIZE  = 5,
    parameter int unsigned LANE_SIZE = 64
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             valid_in,
    input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_array_in,
    output logic                                             valid_out,
    output logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_array_out
);

    // Rotation offset for lane [x][y]. Coordinates outside the 5x5 Keccak
    // grid get no rotation.
    function automatic int unsigned rho_offset(input int unsigned x, input int unsigned y);
        int unsigned off;
        off = 0;
        if (x < 5 && y < 5) begin
            case (x * 5 + y)
                0:       off = 0;
                1:       off = 36;
                2:       off = 3;
                3:       off = 41;
                4:       off = 18;
                5:       off = 1;
                6:       off = 44;
                7:       off = 10;
                8:       off = 45;
                9:       off = 2;
                10:      off = 62;
                11:      off = 6;
                12:      off = 43;
                13:      off = 15;
                14:      off = 61;
                15:      off = 28;
                16:      off = 55;
                17:      off = 25;
                18:      off = 21;
                19:      off = 56;
                20:      off = 27;
                21:      off = 20;
                22:      off = 39;
                23:      off = 8;
                24:      off = 14;
                default: off = 0;
            endcase
        end
        return off;
    endfunction

    logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] rho_state;
    logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_d, state_q;
    logic                                             valid_d, valid_q;

    // out[x][y][z] = in[x][y][(z - OFF) mod w]; the source index is a
    // constant per bit, so no shifter is built.
    for (genvar x = 0; x < ROW_SIZE; x++) begin : g_row
        for (genvar y = 0; y < COL_SIZE; y++) begin : g_col
            localparam int unsigned ROT = rho_offset(x, y) % LANE_SIZE;
            for (genvar z = 0; z < LANE_SIZE; z++) begin : g_bit
                localparam int unsigned SRC = (z + LANE_SIZE - ROT) % LANE_SIZE;
                assign rho_state[x][y][z] = state_array_in[x][y][SRC];
            end
        end
    end

    always_comb begin
        valid_d = valid_in;
        state_d = state_q;
        if (valid_in) begin
            state_d = rho_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            state_q <= '0;
        end else begin
            valid_q <= valid_d;
            state_q <= state_d;
        end
    end

    assign valid_out       = valid_q;
    assign state_array_out = state_q;

endmodule

// File: tb/tb_rho_step_core.sv
module tb_rho_step_core;

    typedef logic [4:0][4:0][63:0] state_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   valid_in = 1'b0;
    state_t state_in = '0;
    logic   valid_out;
    state_t state_out;

    int checks = 0;
    int errors = 0;

    state_t exp_q[$];
    state_t last_out = '0;

    // Rotation offsets indexed [x][y].
    int OFF[5][5] = '{'{0, 36, 3, 41, 18},
                      '{1, 44, 10, 45, 2},
                      '{62, 6, 43, 15, 61},
                      '{28, 55, 25, 21, 56},
                      '{27, 20, 39, 8, 14}};

    rho_step_core #(
        .ROW_SIZE (5),
        .COL_SIZE (5),
        .LANE_SIZE(64)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_in       (valid_in),
        .state_array_in (state_in),
        .valid_out      (valid_out),
        .state_array_out(state_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic state_t rho_model(input state_t s);
        state_t r;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                for (int z = 0; z < 64; z++)
                    r[x][y][z] = s[x][y][(z - OFF[x][y] + 64) % 64];
        return r;
    endfunction

    function automatic state_t rand_state();
        state_t s;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                s[x][y] = {$urandom, $urandom};
        return s;
    endfunction

    task automatic check_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_lane(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag, input state_t got, input state_t exp);
        int bx, by;
        checks++;
        assert (got === exp) else begin
            errors++;
            bx = 0;
            by = 0;
            for (int x = 4; x >= 0; x--)
                for (int y = 4; y >= 0; y--)
                    if (got[x][y] !== exp[x][y]) begin
                        bx = x;
                        by = y;
                    end
            $error("FAIL %s: lane[%0d][%0d] observed %h expected %h",
                   tag, bx, by, got[bx][by], exp[bx][by]);
        end
    endtask

    // Drive one cycle of stimulus (called ~1 time unit after a rising edge),
    // then check the registered result just after the next rising edge.
    task automatic cycle(input logic v, input state_t s, input string tag);
        valid_in = v;
        state_in = s;
        if (v) exp_q.push_back(rho_model(s));
        @(posedge clk);
        #1;
        check_bit({tag, "_valid"}, valid_out, v);
        if (v) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL %s_queue: observed empty expected entry", tag);
            end else begin
                last_out = exp_q.pop_front();
            end
        end
        check_state({tag, v ? "_data" : "_held"}, state_out, last_out);
    endtask

    initial begin
        state_t s;
        state_t ones;

        // Reset state, before any clock edge
        #2;
        check_bit("reset_valid", valid_out, 1'b0);
        check_state("reset_data", state_out, '0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single bit in lane [1][0]
        s = '0;
        s[1][0] = 64'h1;
        cycle(1'b1, s, "single");
        check_lane("single_l10", state_out[1][0], 64'h2);
        check_state("single_rest", state_out, state_t'({63'b0, 1'b1} << (1 * 5 * 64 + 0 * 64 + 1)));

        // All lanes = 1
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                s[x][y] = 64'h1;
        cycle(1'b1, s, "ones_lsb");
        check_lane("lsb_l00", state_out[0][0], 64'h1);
        check_lane("lsb_l20", state_out[2][0], 64'h4000000000000000);
        check_lane("lsb_l13", state_out[1][3], 64'h0000200000000000);
        check_lane("lsb_l44", state_out[4][4], 64'h0000000000004000);

        // Wrap-around and all-ones
        s = '0;
        s[2][4] = 64'h8000000000000000;
        cycle(1'b1, s, "wrap");
        check_lane("wrap_l24", state_out[2][4], 64'h1000000000000000);
        ones = '1;
        cycle(1'b1, ones, "allones");
        check_state("allones_const", state_out, ones);

        // Idle cycle: data must hold
        cycle(1'b0, rand_state(), "idle");

        // Streaming: three back-to-back states then a gap
        for (int i = 0; i < 3; i++) cycle(1'b1, rand_state(), "stream");
        cycle(1'b0, rand_state(), "stream_end");
        cycle(1'b0, rand_state(), "stream_end2");

        // Popcount preserved per lane
        s = rand_state();
        cycle(1'b1, s, "popcnt");
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++) begin
                checks++;
                assert ($countones(state_out[x][y]) == $countones(s[x][y])) else begin
                    errors++;
                    $error("FAIL popcnt_l%0d%0d: observed %0d expected %0d", x, y,
                           $countones(state_out[x][y]), $countones(s[x][y]));
                end
            end

        // Asynchronous reset mid-operation, between edges while valid_out=1
        cycle(1'b1, rand_state(), "pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("async_rst_valid", valid_out, 1'b0);
        check_state("async_rst_data", state_out, '0);
        valid_in = 1'b1;
        state_in = rand_state();
        @(posedge clk);
        #1;
        check_bit("rst_hold_valid", valid_out, 1'b0);
        check_state("rst_hold_data", state_out, '0);
        rst_n = 1'b1;
        last_out = '0;
        cycle(1'b0, rand_state(), "post_rst");
        cycle(1'b0, rand_state(), "post_rst2");
        cycle(1'b1, rand_state(), "post_rst_first");

        // Random states with occasional gaps
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) cycle(1'b0, rand_state(), "rand_gap");
            cycle(1'b1, rand_state(), "rand");
        end
        cycle(1'b0, '0, "final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
